// File: rtl/sdram_arbiter.sv
// Three-master arbiter in front of the SDRAM controller command port.
// Round-robin with a VGA urgent override; read data is steered back in issue order.
module sdram_arbiter #(
    parameter int AW              = 26,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [2:0]           req_valid,
    output logic [2:0]           req_ready,
    input  logic [2:0]           req_write,
    input  logic [3*AW-1:0]      req_addr,
    input  logic [95:0]          req_wdata,
    input  logic [11:0]          req_wstrb,
    input  logic                 vga_urgent,
    output logic [2:0]           rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic                 cmd_write,
    output logic [AW-1:0]        cmd_addr,
    output logic [31:0]          cmd_wdata,
    output logic [3:0]           cmd_wstrb,
    input  logic                 sd_rvalid,
    input  logic [31:0]          sd_rdata,
    output logic                 err_underflow
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

    logic [1:0]    last;
    logic [CW-1:0] count;
    logic [1:0]    id_mem [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    logic          free;
    logic [2:0]    eligible;
    logic [1:0]    order [3];
    logic          grant_any;
    logic          grant_urgent;
    logic [1:0]    grant_id;
    logic          accept_read;
    logic          pop;

    logic          sel_write;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic [3:0]    sel_wstrb;

    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        free = !cmd_valid || cmd_ready;
        for (int i = 0; i < 3; i++) begin
            eligible[i] = req_valid[i] && (req_write[i] || (count < MAX_CNT));
        end
        order[0] = next_port(last);
        order[1] = next_port(order[0]);
        order[2] = last;
    end

    // Urgent VGA wins outright; otherwise search starting just after the last rr winner.
    always_comb begin
        grant_any    = 1'b0;
        grant_urgent = 1'b0;
        grant_id     = 2'd0;
        if (free) begin
            if (vga_urgent && eligible[0]) begin
                grant_any    = 1'b1;
                grant_urgent = 1'b1;
                grant_id     = 2'd0;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (!grant_any && eligible[order[k]]) begin
                        grant_any = 1'b1;
                        grant_id  = order[k];
                    end
                end
            end
        end
    end

    always_comb begin
        req_ready   = grant_any ? (3'b001 << grant_id) : 3'b000;
        accept_read = grant_any && !sel_write;
        pop         = sd_rvalid && (count != '0);
    end

    always_comb begin
        sel_write = req_write[0];
        sel_addr  = req_addr[0 +: AW];
        sel_wdata = req_wdata[0 +: 32];
        sel_wstrb = req_wstrb[0 +: 4];
        case (grant_id)
            2'd1: begin
                sel_write = req_write[1];
                sel_addr  = req_addr[AW +: AW];
                sel_wdata = req_wdata[32 +: 32];
                sel_wstrb = req_wstrb[4 +: 4];
            end
            2'd2: begin
                sel_write = req_write[2];
                sel_addr  = req_addr[2*AW +: AW];
                sel_wdata = req_wdata[64 +: 32];
                sel_wstrb = req_wstrb[8 +: 4];
            end
            default: begin
            end
        endcase
    end

    // Command register: loads on accept, otherwise holds until the controller takes it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid <= 1'b0;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_wstrb <= '0;
            last      <= 2'd2;
        end else begin
            if (grant_any) begin
                cmd_valid <= 1'b1;
                cmd_write <= sel_write;
                cmd_addr  <= sel_addr;
                cmd_wdata <= sel_wdata;
                cmd_wstrb <= sel_wstrb;
            end else if (cmd_ready) begin
                cmd_valid <= 1'b0;
            end
            if (grant_any && !grant_urgent) begin
                last <= grant_id;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (accept_read) begin
            id_mem[wr_ptr] <= grant_id;
        end
    end

    // Outstanding-read bookkeeping and in-order response steering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            rsp_valid     <= 3'b000;
            rsp_rdata     <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (accept_read) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                rsp_valid <= 3'b001 << id_mem[rd_ptr];
                rsp_rdata <= sd_rdata;
            end else begin
                rsp_valid <= 3'b000;
            end
            case ({accept_read, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (sd_rvalid && (count == '0)) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule
